// File: rtl/iram_loader_if.sv
// Host byte link (valid/ready) and instruction-memory write port of the loader.
interface iram_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       iram_we;
    logic [6:0] iram_addr;
    logic [6:0] iram_data_in;

    // Host / memory side: drives bytes, observes ready and the write port.
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  iram_we,
        input  iram_addr,
        input  iram_data_in
    );

    // Loader side: consumes bytes, drives ready and the write port.
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output iram_we,
        output iram_addr,
        output iram_data_in
    );
endinterface

// File: rtl/iram_loader.sv
// Framed program loader: HEADER, LEN, LEN data bytes, CSUM (XOR of data).
// Writes each data byte into the instruction memory, holds the CPU until a
// good image is in, then releases it with cpu_run until the CPU finishes.
module iram_loader #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic         i_clock,
    input  logic         i_reset,
    iram_loader_if.slave io_bus,
    input  logic         i_cpu_finish,
    output logic         o_cpu_run,
    output logic         o_load_done,
    output logic         o_load_error,
    output logic [7:0]   o_word_count
);

    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StRun,
        StErr
    } state_t;

    state_t           r_state;
    logic [7:0]       r_len;
    logic [7:0]       r_xor;
    logic [7:0]       r_word_count;
    logic [IdleW-1:0] r_idle;
    logic             r_iram_we;
    logic [6:0]       r_iram_addr;
    logic [6:0]       r_iram_data;
    logic             r_cpu_run;
    logic             r_load_done;
    logic             r_load_error;

    logic       w_rx_ready;
    logic       w_xfer;
    logic [7:0] w_byte;
    logic [7:0] w_wc_next;
    logic       w_in_frame;
    logic       w_idle_tick;
    logic       w_timeout;

    // Handshake and idle-timer decode.
    always_comb begin
        w_rx_ready  = !i_reset && (r_state != StRun);
        w_byte      = io_bus.rx_data;
        w_xfer      = io_bus.rx_valid && w_rx_ready;
        w_wc_next   = r_word_count + 8'd1;
        w_in_frame  = (r_state == StLen) || (r_state == StData) || (r_state == StCsum);
        w_idle_tick = w_in_frame && !w_xfer;
        w_timeout   = w_idle_tick && (r_idle == IdleW'(TIMEOUT - 1));
    end

    // Frame FSM with registered outputs and the one-cycle write strobe.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_len        <= 8'd0;
            r_xor        <= 8'd0;
            r_word_count <= 8'd0;
            r_idle       <= '0;
            r_iram_we    <= 1'b0;
            r_iram_addr  <= 7'd0;
            r_iram_data  <= 7'd0;
            r_cpu_run    <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_iram_we <= 1'b0;

            // Counts consecutive cycles without a transfer while inside a frame.
            if (w_idle_tick && !w_timeout) begin
                r_idle <= r_idle + IdleW'(1);
            end else begin
                r_idle <= '0;
            end

            if (w_timeout) begin
                r_state      <= StErr;
                r_load_error <= 1'b1;
            end else begin
                case (r_state)
                    StIdle, StErr: begin
                        if (w_xfer && (w_byte == HEADER)) begin
                            r_state      <= StLen;
                            r_load_done  <= 1'b0;
                            r_load_error <= 1'b0;
                            r_word_count <= 8'd0;
                            r_xor        <= 8'd0;
                        end
                    end
                    StLen: begin
                        if (w_xfer) begin
                            if ((w_byte == 8'd0) || (w_byte > 8'd128)) begin
                                r_state      <= StErr;
                                r_load_error <= 1'b1;
                            end else begin
                                r_len   <= w_byte;
                                r_state <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (w_xfer) begin
                            if (w_byte[7]) begin
                                r_state      <= StErr;
                                r_load_error <= 1'b1;
                            end else begin
                                // Address is the pre-increment count, so it tops out at 127.
                                r_iram_we    <= 1'b1;
                                r_iram_addr  <= r_word_count[6:0];
                                r_iram_data  <= w_byte[6:0];
                                r_xor        <= r_xor ^ w_byte;
                                r_word_count <= w_wc_next;
                                if (w_wc_next == r_len) begin
                                    r_state <= StCsum;
                                end
                            end
                        end
                    end
                    StCsum: begin
                        if (w_xfer) begin
                            if (w_byte == r_xor) begin
                                r_load_done <= 1'b1;
                                r_cpu_run   <= 1'b1;
                                r_state     <= StRun;
                            end else begin
                                r_load_error <= 1'b1;
                                r_state      <= StErr;
                            end
                        end
                    end
                    StRun: begin
                        if (i_cpu_finish) begin
                            r_cpu_run <= 1'b0;
                            r_state   <= StIdle;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    // Reset gates the strobe so a write already launched this cycle never lands.
    assign io_bus.rx_ready     = w_rx_ready;
    assign io_bus.iram_we      = r_iram_we && !i_reset;
    assign io_bus.iram_addr    = r_iram_addr;
    assign io_bus.iram_data_in = r_iram_data;

    assign o_cpu_run    = r_cpu_run;
    assign o_load_done  = r_load_done;
    assign o_load_error = r_load_error;
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_iram_loader.sv
// Self-checking bench for iram_loader: expected writes go into a scoreboard
// queue when frames are issued; a negedge monitor pops and compares them.
module tb_iram_loader;

    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic finish;
    logic cpu_run;
    logic load_done;
    logic load_error;
    logic [7:0] word_count;

    iram_loader_if bus ();

    iram_loader #(
        .HEADER  (8'hA5),
        .TIMEOUT (TO)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .io_bus       (bus),
        .i_cpu_finish (finish),
        .o_cpu_run    (cpu_run),
        .o_load_done  (load_done),
        .o_load_error (load_error),
        .o_word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int wr_first = 0;
    int wr_last = 0;
    int wr_seen = 0;
    logic [13:0] exp_q[$];
    logic [7:0]  tx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic push_w(input int addr, input int data);
        logic [6:0] a;
        logic [6:0] d;
        a = addr[6:0];
        d = data[6:0];
        exp_q.push_back({a, d});
    endtask

    // Sends everything in tx_q back-to-back, one byte per clock.
    task automatic send_all();
        while (tx_q.size() > 0) begin
            bus.rx_data  = tx_q.pop_front();
            bus.rx_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
    endtask

    // Write monitor / scoreboard.
    always @(negedge clk) begin
        logic [13:0] e;
        if (bus.iram_we === 1'b1) begin
            if (wr_seen == 0) wr_first = cyc;
            wr_last = cyc;
            wr_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, required no write",
                         bus.iram_addr, bus.iram_data_in);
            end else begin
                e = exp_q.pop_front();
                if ({bus.iram_addr, bus.iram_data_in} !== e) begin
                    n_errors++;
                    $display("FAIL write: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                             bus.iram_addr, bus.iram_data_in, e[13:7], e[6:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        finish       = 1'b0;

        // Reset behaviour.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", int'(bus.rx_ready), 0);
        chk("we_in_reset", int'(bus.iram_we), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(bus.rx_ready), 1);
        chk("rst_run", int'(cpu_run), 0);
        chk("rst_done", int'(load_done), 0);
        chk("rst_err", int'(load_error), 0);
        chk("rst_wc", int'(word_count), 0);
        chk("rst_addr", int'(bus.iram_addr), 0);

        // Junk byte in IDLE is discarded.
        tx_q = '{8'h11};
        send_all();
        @(negedge clk);
        chk("junk_ready", int'(bus.rx_ready), 1);
        chk("junk_err", int'(load_error), 0);
        chk("junk_wc", int'(word_count), 0);

        // Normal load: checksum 12^34^05 = 23.
        push_w(0, 'h12); push_w(1, 'h34); push_w(2, 'h05);
        wr_seen = 0;
        tx_q = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h05, 8'h23};
        send_all();
        @(negedge clk);
        chk("norm_done", int'(load_done), 1);
        chk("norm_run", int'(cpu_run), 1);
        chk("norm_err", int'(load_error), 0);
        chk("norm_wc", int'(word_count), 3);
        chk("norm_ready_run", int'(bus.rx_ready), 0);
        chk("norm_writes", wr_seen, 3);
        chk("norm_span", wr_last - wr_first, 2);
        pulse_finish();
        @(negedge clk);
        chk("finish_run", int'(cpu_run), 0);
        chk("finish_done", int'(load_done), 1);
        chk("finish_ready", int'(bus.rx_ready), 1);

        // Bad checksum (required 03).
        push_w(0, 'h01); push_w(1, 'h02);
        tx_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
        send_all();
        @(negedge clk);
        chk("badcs_err", int'(load_error), 1);
        chk("badcs_done", int'(load_done), 0);
        chk("badcs_run", int'(cpu_run), 0);
        chk("badcs_wc", int'(word_count), 2);
        tx_q = '{8'hA5};
        send_all();
        @(negedge clk);
        chk("hdr_clears_err", int'(load_error), 0);
        push_w(0, 'h7F);
        tx_q = '{8'h01, 8'h7F, 8'h7F};
        send_all();
        @(negedge clk);
        chk("recov_done", int'(load_done), 1);
        chk("recov_wc", int'(word_count), 1);
        pulse_finish();

        // LEN = 0.
        tx_q = '{8'hA5, 8'h00};
        send_all();
        @(negedge clk);
        chk("len0_err", int'(load_error), 1);
        chk("len0_wc", int'(word_count), 0);

        // LEN = 0x81, entered from ERR.
        tx_q = '{8'hA5, 8'h81};
        send_all();
        @(negedge clk);
        chk("len81_err", int'(load_error), 1);
        chk("len81_wc", int'(word_count), 0);

        // Data byte with bit7 set.
        push_w(0, 'h12);
        tx_q = '{8'hA5, 8'h03, 8'h12, 8'h80};
        send_all();
        @(negedge clk);
        chk("bit7_err", int'(load_error), 1);
        chk("bit7_wc", int'(word_count), 1);

        // Full 128-word image, data = address; XOR of 0..127 is 00.
        wr_seen = 0;
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h80);
        for (int i = 0; i < 128; i++) begin
            tx_q.push_back(8'(i));
            push_w(i, i);
        end
        tx_q.push_back(8'h00);
        send_all();
        @(negedge clk);
        chk("full_done", int'(load_done), 1);
        chk("full_err", int'(load_error), 0);
        chk("full_wc", int'(word_count), 128);
        chk("full_writes", wr_seen, 128);
        chk("full_span", wr_last - wr_first, 127);
        pulse_finish();

        // Timeout: TO-1 idle cycles are tolerated, the TO-th one errors.
        push_w(0, 'h01);
        tx_q = '{8'hA5, 8'h04, 8'h01};
        send_all();
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        chk("to_short_err", int'(load_error), 0);
        push_w(1, 'h02);
        tx_q = '{8'h02};
        send_all();
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        chk("to_before_err", int'(load_error), 0);
        @(posedge clk);
        @(negedge clk);
        chk("to_err", int'(load_error), 1);
        chk("to_wc", int'(word_count), 2);

        // Reset right after the 2nd data byte: that write must not land.
        push_w(0, 'h11);
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22};
        send_all();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", int'(bus.rx_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_wc", int'(word_count), 0);
        chk("midrst_addr", int'(bus.iram_addr), 0);
        chk("midrst_data", int'(bus.iram_data_in), 0);
        chk("midrst_err", int'(load_error), 0);
        chk("midrst_done", int'(load_done), 0);
        chk("midrst_run", int'(cpu_run), 0);
        push_w(0, 'h0A); push_w(1, 'h0B);
        tx_q = '{8'hA5, 8'h02, 8'h0A, 8'h0B, 8'h01};
        send_all();
        @(negedge clk);
        chk("post_done", int'(load_done), 1);
        chk("post_run", int'(cpu_run), 1);
        chk("post_wc", int'(word_count), 2);
        pulse_finish();

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
